// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Desc   : Opcode map, fetch FSM state encoding and opcode classification
//          helpers shared by the fetch sequencer and the ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_LDA_I    = 8'h01;
    localparam logic [7:0] OP_LDB_I    = 8'h02;
    localparam logic [7:0] OP_STA      = 8'h03;
    localparam logic [7:0] OP_JMP      = 8'h04;
    localparam logic [7:0] OP_JZ       = 8'h05;
    localparam logic [7:0] OP_JNZ      = 8'h06;
    localparam logic [7:0] OP_ARG_LAST = 8'h0F;
    localparam logic [7:0] OP_ADD      = 8'h10;
    localparam logic [7:0] OP_SUB      = 8'h11;
    localparam logic [7:0] OP_AND      = 8'h12;
    localparam logic [7:0] OP_OR       = 8'h13;
    localparam logic [7:0] OP_XOR      = 8'h14;
    localparam logic [7:0] OP_SHL      = 8'h15;
    localparam logic [7:0] OP_SHR      = 8'h16;
    localparam logic [7:0] OP_NOT      = 8'h17;
    localparam logic [7:0] OP_HLT      = 8'hFF;

    typedef enum logic [2:0] {
        REQ_OP   = 3'd0,
        WAIT_OP  = 3'd1,
        REQ_ARG  = 3'd2,
        WAIT_ARG = 3'd3,
        ISSUE    = 3'd4,
        HALT     = 3'd5
    } fetch_state_t;

    // Every opcode in 01..0F carries one immediate/address byte.
    function automatic logic needs_arg(input logic [7:0] op);
        return (op >= OP_LDA_I) && (op <= OP_ARG_LAST);
    endfunction

    function automatic logic is_illegal(input logic [7:0] op);
        return !((op == OP_NOP) || needs_arg(op) ||
                 ((op >= OP_ADD) && (op <= OP_NOT)) || (op == OP_HLT));
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_seq.sv
// ============================================================================
// Module : fetch_seq
// Desc   : Instruction fetch/sequencer: reads opcode (+operand) bytes from a
//          pipelined byte memory and issues bundles over valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_seq
    import fetch_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         MEM_LAT  = 1
)
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] addr,
    output logic       rd_en,
    input  logic [7:0] data_in,
    output logic       issue_valid,
    input  logic       issue_ready,
    output logic [7:0] issue_op,
    output logic [7:0] issue_arg,
    output logic [7:0] issue_pc,
    output logic       issue_illegal,
    input  logic       redir_valid,
    input  logic [7:0] redir_pc,
    output logic       halted
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    fetch_state_t r_state;
    logic [7:0]   r_pc;
    logic [7:0]   r_op_pc;
    logic [7:0]   r_op;
    logic [2:0]   r_lat_cnt;
    logic         w_lat_done;

    assign w_lat_done = (r_lat_cnt == LAT);

    // rd_en/addr are registered, so they are loaded on the edge that enters a
    // request state. Out of reset the FSM sits in REQ_OP with rd_en low and
    // spends one cycle raising the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= REQ_OP;
            r_pc          <= RESET_PC;
            r_op_pc       <= 8'h00;
            r_op          <= 8'h00;
            r_lat_cnt     <= 3'd0;
            addr          <= RESET_PC;
            rd_en         <= 1'b0;
            issue_valid   <= 1'b0;
            issue_op      <= 8'h00;
            issue_arg     <= 8'h00;
            issue_pc      <= 8'h00;
            issue_illegal <= 1'b0;
            halted        <= 1'b0;
        end else if (redir_valid) begin
            r_state     <= REQ_OP;
            r_pc        <= redir_pc;
            r_lat_cnt   <= 3'd0;
            addr        <= redir_pc;
            rd_en       <= 1'b1;
            issue_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (r_state)
                REQ_OP: begin
                    if (!rd_en) begin
                        rd_en <= 1'b1;
                        addr  <= r_pc;
                    end else begin
                        rd_en     <= 1'b0;
                        r_op_pc   <= r_pc;
                        r_pc      <= r_pc + 8'd1;
                        r_lat_cnt <= 3'd1;
                        r_state   <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (w_lat_done) begin
                        r_op <= data_in;
                        if (needs_arg(data_in)) begin
                            rd_en   <= 1'b1;
                            addr    <= r_pc;
                            r_state <= REQ_ARG;
                        end else begin
                            issue_valid   <= 1'b1;
                            issue_op      <= data_in;
                            issue_arg     <= 8'h00;
                            issue_pc      <= r_op_pc;
                            issue_illegal <= is_illegal(data_in);
                            r_state       <= ISSUE;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                REQ_ARG: begin
                    rd_en     <= 1'b0;
                    r_pc      <= r_pc + 8'd1;
                    r_lat_cnt <= 3'd1;
                    r_state   <= WAIT_ARG;
                end
                WAIT_ARG: begin
                    if (w_lat_done) begin
                        issue_valid   <= 1'b1;
                        issue_op      <= r_op;
                        issue_arg     <= data_in;
                        issue_pc      <= r_op_pc;
                        issue_illegal <= is_illegal(r_op);
                        r_state       <= ISSUE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                ISSUE: begin
                    if (issue_ready) begin
                        issue_valid <= 1'b0;
                        if (issue_op == OP_HLT) begin
                            halted  <= 1'b1;
                            r_state <= HALT;
                        end else begin
                            rd_en   <= 1'b1;
                            addr    <= r_pc;
                            r_state <= REQ_OP;
                        end
                    end
                end
                HALT: begin
                    rd_en <= 1'b0;
                end
                default: begin
                    rd_en   <= 1'b0;
                    r_state <= REQ_OP;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_seq.sv
// ============================================================================
// Module : tb_fetch_seq
// Desc   : Self-checking bench for fetch_seq: two instances (MEM_LAT=1 at
//          PC 00, MEM_LAT=3 at PC FF) with pipelined memory models and a
//          scoreboard of expected issue bundles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_seq;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] pc;
        logic       ill;
    } bundle_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rd_en_a, valid_a, ready_a, ill_a, redir_a, halted_a;
    logic [7:0] addr_a, data_a, op_a, arg_a, pc_a, rpc_a;
    logic       rst_b, rd_en_b, valid_b, ready_b, ill_b, redir_b, halted_b;
    logic [7:0] addr_b, data_b, op_b, arg_b, pc_b, rpc_b;

    fetch_seq #(.RESET_PC(8'h00), .MEM_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .addr(addr_a), .rd_en(rd_en_a), .data_in(data_a),
        .issue_valid(valid_a), .issue_ready(ready_a), .issue_op(op_a),
        .issue_arg(arg_a), .issue_pc(pc_a), .issue_illegal(ill_a),
        .redir_valid(redir_a), .redir_pc(rpc_a), .halted(halted_a)
    );

    fetch_seq #(.RESET_PC(8'hFF), .MEM_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst_b), .addr(addr_b), .rd_en(rd_en_b), .data_in(data_b),
        .issue_valid(valid_b), .issue_ready(ready_b), .issue_op(op_b),
        .issue_arg(arg_b), .issue_pc(pc_b), .issue_illegal(ill_b),
        .redir_valid(redir_b), .redir_pc(rpc_b), .halted(halted_b)
    );

    // Pipelined memories; EE is driven whenever no read is due, so sampling on
    // the wrong cycle shows up as an illegal opcode.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] pipe_a;
    logic       pv_a = 1'b0;
    logic [7:0] pipe_b [3];
    logic [2:0] pv_b = 3'b000;

    always @(posedge clk) begin
        pipe_a    <= mem_a[addr_a];
        pv_a      <= rd_en_a;
        pipe_b[0] <= mem_b[addr_b];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        pv_b      <= {pv_b[1:0], rd_en_b};
    end
    assign data_a = pv_a    ? pipe_a    : 8'hEE;
    assign data_b = pv_b[2] ? pipe_b[2] : 8'hEE;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    bundle_t sb_a [$];
    bundle_t sb_b [$];
    bundle_t e_a, e_b;

    always @(negedge clk) begin
        if (!rst_a && valid_a && ready_a) begin
            if (sb_a.size() == 0) check("a_unexpected_issue", 32'({op_a, pc_a}), 32'h0);
            else begin
                e_a = sb_a.pop_front();
                check("a_bundle", 32'({op_a, arg_a, pc_a, ill_a}), 32'(e_a));
            end
        end
        if (!rst_b && valid_b && ready_b) begin
            if (sb_b.size() == 0) check("b_unexpected_issue", 32'({op_b, pc_b}), 32'h0);
            else begin
                e_b = sb_b.pop_front();
                check("b_bundle", 32'({op_b, arg_b, pc_b, ill_b}), 32'(e_b));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return rd_en_a;
            1:       return valid_a;
            2:       return halted_a;
            3:       return rd_en_b;
            4:       return valid_b;
            default: return halted_b;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string tag, output int n);
        n = 0;
        while (!sig(which) && n < 200) begin
            tick();
            n++;
        end
        if (!sig(which)) begin
            check(tag, 32'(n), 32'hFFFF_FFFF);
            n = -1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'hFF;
            mem_b[i] = 8'hFF;
        end
    endtask

    function automatic bundle_t mk(input logic [7:0] op, input logic [7:0] arg,
                                   input logic [7:0] pc, input logic ill);
        return '{op: op, arg: arg, pc: pc, ill: ill};
    endfunction

    task automatic restart_a();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
    endtask

    task automatic restart_b();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        rst_a = 1'b1; rst_b = 1'b1;
        ready_a = 1'b1; ready_b = 1'b1;
        redir_a = 1'b0; redir_b = 1'b0;
        rpc_a = 8'h00; rpc_b = 8'h00;
        clear_mem();
        tick();
        tick();
        check("rst_ctl_a", 32'({rd_en_a, valid_a, halted_a, ill_a}), 32'h0);
        check("rst_addr_a", 32'(addr_a), 32'h00);
        check("rst_bundle_a", 32'({op_a, arg_a, pc_a}), 32'h0);
        check("rst_addr_b", 32'(addr_b), 32'hFF);

        // One-byte ALU op, MEM_LAT=1
        mem_a[8'h00] = 8'h10;
        sb_a.push_back(mk(8'h10, 8'h00, 8'h00, 1'b0));
        sb_a.push_back(mk(8'hFF, 8'h00, 8'h01, 1'b0));
        rst_a = 1'b0;
        wait_sig(0, "t1_rd_timeout", n);
        check("t1_addr0", 32'(addr_a), 32'h00);
        wait_sig(1, "t1_valid_timeout", n);
        check("t1_lat", 32'(n), 32'd2);
        tick();
        check("t1_next_req", 32'({rd_en_a, addr_a}), 32'h101);
        wait_sig(2, "t1_halt_timeout", n);

        // Two-byte op
        clear_mem();
        mem_a[8'h00] = 8'h01;
        mem_a[8'h01] = 8'h5A;
        sb_a.push_back(mk(8'h01, 8'h5A, 8'h00, 1'b0));
        sb_a.push_back(mk(8'hFF, 8'h00, 8'h02, 1'b0));
        restart_a();
        wait_sig(0, "t2_rd_timeout", n);
        check("t2_addr0", 32'(addr_a), 32'h00);
        tick();
        tick();
        check("t2_arg_req", 32'({rd_en_a, addr_a}), 32'h101);
        tick();
        tick();
        check("t2_valid_c4", 32'(valid_a), 32'h1);
        tick();
        check("t2_next_req", 32'({rd_en_a, addr_a}), 32'h102);
        wait_sig(2, "t2_halt_timeout", n);

        // Backpressure
        clear_mem();
        mem_a[8'h00] = 8'h12;
        sb_a.push_back(mk(8'h12, 8'h00, 8'h00, 1'b0));
        sb_a.push_back(mk(8'hFF, 8'h00, 8'h01, 1'b0));
        ready_a = 1'b0;
        restart_a();
        wait_sig(1, "t3_valid_timeout", n);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold", 32'({valid_a, rd_en_a, op_a, pc_a}), 32'h2_1200);
            tick();
        end
        ready_a = 1'b1;
        tick();
        check("t3_after_xfer", 32'({valid_a, rd_en_a, addr_a}), 32'h101);
        wait_sig(2, "t3_halt_timeout", n);

        // Redirect during WAIT_ARG drops the partial two-byte op
        clear_mem();
        mem_a[8'h00] = 8'h01;
        mem_a[8'h01] = 8'h77;
        mem_a[8'h40] = 8'h13;
        sb_a.push_back(mk(8'h13, 8'h00, 8'h40, 1'b0));
        sb_a.push_back(mk(8'hFF, 8'h00, 8'h41, 1'b0));
        restart_a();
        wait_sig(0, "t4_rd_timeout", n);
        tick();
        tick();
        tick();
        rpc_a = 8'h40;
        redir_a = 1'b1;
        tick();
        redir_a = 1'b0;
        check("t4_redir_req", 32'({valid_a, rd_en_a, addr_a}), 32'h140);
        wait_sig(2, "t4_halt_timeout", n);

        // HLT holds, redirect wakes it
        clear_mem();
        mem_a[8'h00] = 8'hFF;
        mem_a[8'h10] = 8'h14;
        sb_a.push_back(mk(8'hFF, 8'h00, 8'h00, 1'b0));
        restart_a();
        wait_sig(2, "t6_halt_timeout", n);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!halted_a || rd_en_a || valid_a) bad++;
            tick();
        end
        check("t6_halt_hold", 32'(bad), 32'd0);
        sb_a.push_back(mk(8'h14, 8'h00, 8'h10, 1'b0));
        sb_a.push_back(mk(8'hFF, 8'h00, 8'h11, 1'b0));
        rpc_a = 8'h10;
        redir_a = 1'b1;
        tick();
        redir_a = 1'b0;
        check("t6_wake", 32'({halted_a, rd_en_a, addr_a}), 32'h110);
        wait_sig(2, "t6_halt2_timeout", n);

        // Reset during WAIT_OP
        clear_mem();
        mem_a[8'h00] = 8'hFF;
        restart_a();
        wait_sig(0, "t7_rd_timeout", n);
        tick();
        rst_a = 1'b1;
        tick();
        check("t7_rst_ctl", 32'({rd_en_a, valid_a, halted_a, ill_a}), 32'h0);
        check("t7_rst_bus", 32'({addr_a, op_a, arg_a, pc_a}), 32'h0);
        rst_a = 1'b0;
        sb_a.push_back(mk(8'hFF, 8'h00, 8'h00, 1'b0));
        wait_sig(2, "t7_halt_timeout", n);
        rst_a = 1'b1;

        // PC wrap with MEM_LAT=3 and RESET_PC=FF, then an illegal opcode
        clear_mem();
        mem_b[8'hFF] = 8'h02;
        mem_b[8'h00] = 8'h33;
        mem_b[8'h01] = 8'h20;
        sb_b.push_back(mk(8'h02, 8'h33, 8'hFF, 1'b0));
        sb_b.push_back(mk(8'h20, 8'h00, 8'h01, 1'b1));
        sb_b.push_back(mk(8'hFF, 8'h00, 8'h02, 1'b0));
        rst_b = 1'b0;
        wait_sig(3, "t5_rd_timeout", n);
        check("t5_addr0", 32'(addr_b), 32'hFF);
        wait_sig(4, "t5_valid_timeout", n);
        check("t5_lat", 32'(n), 32'd8);
        tick();
        check("t5_next_req", 32'({rd_en_b, addr_b}), 32'h101);
        wait_sig(5, "t5_halt_timeout", n);

        // Redirect in WAIT_ARG at MEM_LAT=3; stale operand must not be taken
        clear_mem();
        mem_b[8'hFF] = 8'h01;
        mem_b[8'h00] = 8'hAA;
        mem_b[8'h40] = 8'h11;
        sb_b.push_back(mk(8'h11, 8'h00, 8'h40, 1'b0));
        sb_b.push_back(mk(8'hFF, 8'h00, 8'h41, 1'b0));
        restart_b();
        wait_sig(3, "t8_rd_timeout", n);
        for (int i = 0; i < 5; i++) tick();
        rpc_b = 8'h40;
        redir_b = 1'b1;
        tick();
        redir_b = 1'b0;
        check("t8_redir_req", 32'({rd_en_b, addr_b}), 32'h140);
        wait_sig(4, "t8_valid_timeout", n);
        check("t8_lat", 32'(n), 32'd4);
        wait_sig(5, "t8_halt_timeout", n);

        check("a_sb_left", 32'(sb_a.size()), 32'd0);
        check("b_sb_left", 32'(sb_b.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction fetch/sequencer for the 8-bit core. It sits upstream of the ALU/execute stage. It reads opcode bytes, plus an operand byte where the opcode needs one, from byte-wide memory at the PC. It hands each decoded instruction bundle downstream over a valid/ready handshake and accepts PC redirects (jumps/branches) back from execute.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.
MEM_LAT, 1, fixed read latency of memory in cycles (legal 1..4). Memory is fully pipelined.

Ports:
clk  in  1  system clock; all state on posedge.
rst  in  1  reset: one clock; synchronous, active-high.
addr  out  8  memory read address.
rd_en  out  1  read strobe, one cycle per byte request.
data_in  in  8  read data; valid exactly MEM_LAT cycles after the rd_en cycle.
issue_valid  out  1  bundle valid.
issue_ready  in  1  downstream accepts; transfer when valid&&ready.
issue_op  out  8  opcode byte.
issue_arg  out  8  operand byte; 8'h00 for one-byte opcodes.
issue_pc  out  8  address of opcode byte.
issue_illegal  out  1  opcode is undefined.
redir_valid  in  1  redirect request.
redir_pc  in  8  redirect target.
halted  out  1  fetch stopped after HLT.

Behaviour:
- Reset values: addr=RESET_PC, rd_en=0, issue_valid=0, issue_op/arg/pc=0, issue_illegal=0, halted=0. State = REQ_OP, pc=RESET_PC.
- Reset mid-operation discards all in-flight reads. Data returning after reset is never sampled.
- Opcode classes:
  - 8'h00: NOP, one byte.
  - 8'h01..8'h0F: two-byte; operand follows the opcode.
  - 8'h10..8'h17: ALU ops, one byte.
  - 8'hFF: HLT, one byte.
  - All other values: one byte, issue_illegal=1.
- States:
  - REQ_OP: addr=pc, rd_en=1 for one cycle; pc<=pc+1; go to WAIT_OP with lat_cnt=1.
  - WAIT_OP: lat_cnt increments. When lat_cnt==MEM_LAT, sample data_in into op. Two-byte opcodes go to REQ_ARG; all others go to ISSUE.
  - REQ_ARG / WAIT_ARG: same as REQ_OP / WAIT_OP; sampled byte goes to arg, then go to ISSUE.
  - ISSUE: issue_valid=1, bundle held stable until the handshake.
    - On valid&&ready: HLT goes to HALT; otherwise go to REQ_OP.
    - issue_valid deasserts the cycle after transfer.
  - HALT: halted=1, rd_en=0. Stays here until redir_valid.
- Latency (REQ_OP cycle = 0, ready held 1):
  - One-byte instruction: issue_valid in cycle MEM_LAT+1.
  - Two-byte instruction: issue_valid in cycle 2*MEM_LAT+2.
  - Next REQ_OP occurs the cycle after transfer.
  - No prefetch overlap.
- Backpressure: while issue_valid && !issue_ready, rd_en=0 and all issue_* outputs are unchanged.
- PC arithmetic is 8-bit modulo: 8'hFF+1=8'h00. A two-byte opcode at 8'hFF fetches its operand from 8'h00.
- Redirect has highest priority, in any state including HALT:
  - pc<=redir_pc, state<=REQ_OP, issue_valid<=0, halted<=0 at the next edge.
  - Any outstanding read is ignored: lat_cnt restarts, and the pipelined memory returns the stale byte before the new one.
  - A partially fetched two-byte instruction is dropped.
  - Redirect in the same cycle as an issue transfer: the transfer completes, and the redirect is still applied.
- rst and redir_valid together: reset wins.
- rd_en is never asserted in ISSUE or HALT.

Decomposition:
- Shared package fetch_pkg:
  - Opcode constants: OP_NOP, OP_LDA_I, ..., OP_ADD..OP_NOT, OP_HLT.
  - State enum fetch_state_t: REQ_OP, WAIT_OP, REQ_ARG, WAIT_ARG, ISSUE, HALT.
  - Functions needs_arg(op) and is_illegal(op).
  - The ALU uses the same opcode constants.
- No sub-module; a single FSM with a 3-bit lat_cnt.

Test Plan:
- MEM_LAT=1, rst then release, mem[00]=10, ready=1 -> rd_en@cycle0 addr=00; issue_valid@cycle2 op=10 arg=00 pc=00 illegal=0; rd_en@cycle3 addr=01.
- mem[00]=01, mem[01]=5A -> reads at 00 then 01; issue_valid@cycle4 op=01 arg=5A pc=00; next addr=02.
- Backpressure: issue_ready=0 for 5 cycles during ISSUE -> bundle stable, rd_en=0 throughout; transfer on ready=1; next REQ_OP the following cycle.
- Redirect to 40 asserted in WAIT_ARG of mem[00]=01 -> no issue of op 01; next cycle rd_en=1 addr=40. Repeat with MEM_LAT=3 and mem[40]=11 -> issue op=11 pc=40, never the stale byte.
- RESET_PC=FF, mem[FF]=02, mem[00]=33 -> issue op=02 arg=33 pc=FF; next addr=01. Also mem[01]=20 -> issue_illegal=1 op=20.
- mem[00]=FF -> issue op=FF, then halted=1 and rd_en=0 for 100 cycles; redir_valid to 10 -> halted=0, rd_en addr=10 next cycle. rst asserted in WAIT_OP -> reset values next edge.
